counter_mode_arbiter: RTL and testbench

Round-robin arbiter that shares the mode input of the up/even/odd/hold counter FSM between several requesters. Each requester asks for the counter with a req/gnt handshake and supplies a 2-bit mode code. The arbiter grants one owner at a time, bounds each tenure with a programmable dwell limit, and drives the counter's one-hot `{HOLD, ODD, EVEN, UP}` mode vector. When no one owns the counter, that vector is HOLD.

---
 rtl/counter_mode_arbiter_pkg.sv | 35 +++
 rtl/counter_mode_arbiter_rr_pick.sv | 46 ++++
 rtl/counter_mode_arbiter.sv | 128 ++++++++++++
 tb/tb_counter_mode_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mode_arbiter_pkg.sv
// counter_mode_arbiter_pkg
// Constants and types shared by the counter-mode arbiter and the counter FSM
// it feeds: the 2-bit mode codes that requesters supply, the one-hot
// {HOLD, ODD, EVEN, UP} vector the counter consumes, the arbiter state
// encoding, and a decode helper from mode code to one-hot vector.
package counter_mode_arbiter_pkg;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_EVEN = 2'b01;
    localparam logic [1:0] MODE_ODD  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [3:0] X_UP   = 4'b0001;
    localparam logic [3:0] X_EVEN = 4'b0010;
    localparam logic [3:0] X_ODD  = 4'b0100;
    localparam logic [3:0] X_HOLD = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    function automatic logic [3:0] mode_decode(input logic [1:0] code);
        logic [3:0] x;
        case (code)
            MODE_UP:   x = X_UP;
            MODE_EVEN: x = X_EVEN;
            MODE_ODD:  x = X_ODD;
            default:   x = X_HOLD;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/counter_mode_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Starting at index ptr and moving upward
// modulo N_REQ, the first requester with req set wins.
// Ports:
//   req   - per-requester request vector
//   ptr   - index where the search starts
//   valid - high when any request is set
//   win   - index of the winning requester (0 when valid is low)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] win
);

    // cand_idx[k] is the requester visited k steps after ptr. ptr < N_REQ and
    // k < N_REQ, so one conditional subtraction is enough for the wrap.
    logic [PTR_W-1:0] cand_idx [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [PTR_W:0] sum;
            assign sum = {1'b0, ptr} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (PTR_W+1)'(N_REQ))
                                  ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                  : PTR_W'(sum);
        end
    endgenerate

    // Walk from the farthest candidate back to ptr so the closest one wins.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                valid = 1'b1;
                win   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/counter_mode_arbiter.sv
// counter_mode_arbiter
// Round-robin arbiter sharing the mode input of the up/even/odd/hold counter
// among N_REQ requesters. One owner at a time is granted via req/gnt; its
// 2-bit mode code is decoded into the counter's one-hot x vector. Tenures
// end on release, on the owner dropping req, or after max_dwell cycles
// (0 = unlimited). Every tenure is followed by one GAP cycle and one IDLE
// cycle, so the counter always sees HOLD between owners.
// Ports:
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset
//   req       - per-requester request (level)
//   rel       - per-requester release pulse, only the owner's is honoured
//   mode      - per-requester mode code, bits [2i+1:2i] for requester i
//   max_dwell - tenure limit in cycles, sampled at grant, 0 = unlimited
//   gnt       - one-hot grant (registered)
//   owner     - index of current or most recent owner (registered)
//   busy      - high while a tenure is running (registered)
//   x_out     - one-hot {HOLD, ODD, EVEN, UP} to the counter (registered)
module counter_mode_arbiter
    import counter_mode_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DWELL_W = 4,
    localparam int PTR_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     rel,
    input  logic [2*N_REQ-1:0]   mode,
    input  logic [DWELL_W-1:0]   max_dwell,
    output logic [N_REQ-1:0]     gnt,
    output logic [PTR_W-1:0]     owner,
    output logic                 busy,
    output logic [3:0]           x_out
);

    arb_state_t         state_reg;
    logic [PTR_W-1:0]   ptr_reg;
    logic [PTR_W-1:0]   owner_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic               busy_reg;
    logic [3:0]         x_out_reg;
    logic [DWELL_W-1:0] dcnt_reg;

    logic [1:0]         mode_arr [N_REQ];
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               run_exit;
    logic [PTR_W-1:0]   ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mode
            assign mode_arr[gi] = mode[2*gi +: 2];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .win   (pick_idx)
    );

    // dcnt is loaded with max_dwell at grant and only counts while non-zero,
    // so dcnt == 1 can only occur in a limited tenure; a zero load keeps the
    // tenure unlimited without a separate flag.
    assign run_exit = rel[owner_reg] | ~req[owner_reg] |
                      (dcnt_reg == DWELL_W'(1));

    assign ptr_next = (owner_reg == PTR_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
            x_out_reg <= X_HOLD;
            dcnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg <= ST_RUN;
                        gnt_reg   <= N_REQ'(1) << pick_idx;
                        owner_reg <= pick_idx;
                        busy_reg  <= 1'b1;
                        dcnt_reg  <= max_dwell;
                        x_out_reg <= mode_decode(mode_arr[pick_idx]);
                    end
                end
                ST_RUN: begin
                    if (run_exit) begin
                        state_reg <= ST_GAP;
                        gnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        x_out_reg <= X_HOLD;
                        dcnt_reg  <= '0;
                    end else begin
                        x_out_reg <= mode_decode(mode_arr[owner_reg]);
                        if (dcnt_reg != '0) begin
                            dcnt_reg <= dcnt_reg - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    ptr_reg   <= ptr_next;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt   = gnt_reg;
    assign owner = owner_reg;
    assign busy  = busy_reg;
    assign x_out = x_out_reg;

endmodule

// File: tb/tb_counter_mode_arbiter.sv
// tb_counter_mode_arbiter
// Scoreboard bench: a reference model samples the inputs on every rising
// edge and queues the outputs the arbiter should present afterwards; a
// separate monitor pops one entry per cycle and compares. Directed scenarios
// are followed by randomized traffic with occasional asynchronous resets.
module tb_counter_mode_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  rel = '0;
    logic [2*N-1:0] mode = '0;
    logic [DW-1:0] max_dwell = '0;
    logic [N-1:0]  gnt;
    logic [PW-1:0] owner;
    logic          busy;
    logic [3:0]    x_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [PW-1:0] owner;
        logic          busy;
        logic [3:0]    x;
    } exp_t;

    exp_t exp_q[$];

    counter_mode_arbiter #(.N_REQ(N), .DWELL_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .rel       (rel),
        .mode      (mode),
        .max_dwell (max_dwell),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .x_out     (x_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // holder: current owner or -1; left: remaining cycles of a limited tenure;
    // cooling: the one cycle after a tenure in which nobody may be granted.
    int m_holder  = -1;
    int m_left    = 0;
    bit m_limited = 0;
    bit m_cooling = 0;
    int m_next    = 0;
    int m_owner   = 0;

    function automatic logic [3:0] code_to_x(input int code);
        return 4'(1 << code);
    endfunction

    initial begin
        forever begin
            exp_t e;
            logic [N-1:0]   s_req;
            logic [N-1:0]   s_rel;
            logic [2*N-1:0] s_mode;
            int             s_md;
            @(posedge clk);
            s_req  = req;
            s_rel  = rel;
            s_mode = mode;
            s_md   = int'(max_dwell);
            if (!reset_n) begin
                m_holder = -1; m_left = 0; m_limited = 0;
                m_cooling = 0; m_next = 0; m_owner = 0;
            end else if (m_holder >= 0) begin
                if (s_rel[m_holder] || !s_req[m_holder] || (m_limited && m_left == 1)) begin
                    m_next    = (m_holder + 1) % N;
                    m_holder  = -1;
                    m_cooling = 1;
                end else if (m_limited) begin
                    m_left--;
                end
            end else if (m_cooling) begin
                m_cooling = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_next + k) % N;
                    if (m_holder < 0 && s_req[idx]) begin
                        m_holder  = idx;
                        m_owner   = idx;
                        m_left    = s_md;
                        m_limited = (s_md != 0);
                    end
                end
            end
            e.owner = PW'(m_owner);
            if (m_holder >= 0) begin
                e.gnt  = N'(1 << m_holder);
                e.busy = 1'b1;
                e.x    = code_to_x(int'(s_mode[2*m_holder +: 2]));
            end else begin
                e.gnt  = '0;
                e.busy = 1'b0;
                e.x    = 4'b1000;
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("gnt",   32'(gnt),   32'(e.gnt));
                check("owner", 32'(owner), 32'(e.owner));
                check("busy",  32'(busy),  32'(e.busy));
                check("x_out", 32'(x_out), 32'(e.x));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(gnt),   32'h0);
        check({tag, "_owner"}, 32'(owner), 32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
        check({tag, "_x_out"}, 32'(x_out), 32'h8);
    endtask

    // Asserts reset between edges, checks outputs before any clock edge,
    // holds reset across one rising edge, releases at the following negedge.
    task automatic async_reset_pulse(input string tag);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_busy(input string tag, input int limit);
        int waited;
        waited = 0;
        while (!busy && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (!busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got busy=0 expected busy=1 within %0d cycles", tag, limit);
        end
    endtask

    initial begin
        // Reset held with random inputs.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = N'($urandom); rel = N'($urandom);
            mode = (2*N)'($urandom); max_dwell = DW'($urandom);
            check_reset_outputs("rst_hold");
        end

        // Release with a single requester 2 in EVEN.
        @(negedge clk);
        req = 4'b0100; rel = '0; max_dwell = '0;
        mode = (2*N)'($urandom);
        mode[5:4] = 2'b01;
        reset_n = 1'b1;
        cycles(4);
        req = '0;
        cycles(4);

        // Dwell limit of 3, requester 0 held in UP.
        mode = '0; max_dwell = 4'd3; req = 4'b0001;
        cycles(14);
        req = '0;
        cycles(4);

        // Round-robin with everybody requesting, 2-cycle tenures.
        req = 4'b1111; max_dwell = 4'd2;
        mode = 8'b11_10_01_00;
        cycles(20);
        req = '0;
        cycles(4);

        // Release on the final dwell cycle, plus a non-owner release.
        req = 4'b0011; max_dwell = 4'd2;
        wait_busy("rel_vs_dwell", 10);
        rel = 4'b0010;             // requester 1 is not the owner here
        @(negedge clk);
        rel = 4'b0011;             // owner release on the last dwell cycle
        @(negedge clk);
        rel = '0;
        cycles(10);
        req = '0;
        cycles(4);

        // Mid-tenure mode change for owner 2, then drop req.
        max_dwell = '0; mode = '0; mode[5:4] = 2'b01; req = 4'b0100;
        cycles(4);
        mode[5:4] = 2'b10;
        cycles(3);
        req = '0;
        cycles(4);

        // Asynchronous reset during a tenure.
        req = 4'b1010; max_dwell = '0;
        wait_busy("mid_run", 10);
        cycles(2);
        async_reset_pulse("rst_mid_run");
        cycles(6);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            for (int b = 0; b < N; b++) begin
                rel[b] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 3) == 0) mode = (2*N)'($urandom);
            max_dwell = DW'($urandom_range(0, 5));
            if ($urandom_range(0, 199) == 0) async_reset_pulse("rst_random");
        end

        rel = '0; req = '0;
        cycles(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
